main_to_cache_refill: RTL

MAIN_TO_CACHE_REFILL -- requirements
Module: main_to_cache_refill

---
 rtl/kasumi_cache_pkg.sv | 23 ++
 rtl/cache_sync_fifo.sv | 60 ++++++
 rtl/main_to_cache_refill.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/kasumi_cache_pkg.sv
// Shared defaults, refill FSM state encoding and line-offset helpers for the
// main-memory-to-cache refill path.
package kasumi_cache_pkg;

  localparam int unsigned FIFO_WIDTH_DEF = 32;
  localparam int unsigned LINE_WORDS_DEF = 8;
  localparam int unsigned DEPTH_DEF      = 8;

  // Byte-offset bits inside a line: word index bits plus 2 byte-in-word bits.
  localparam int unsigned LINE_OFF_W = $clog2(LINE_WORDS_DEF) + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } refill_state_e;

  function automatic int unsigned line_off_w(input int unsigned line_words);
    return $clog2(line_words) + 2;
  endfunction

endpackage

// File: rtl/cache_sync_fifo.sv
// Single-clock FIFO holding returned refill words; exposes occupancy so the
// refill controller can budget memory requests against free space.
module cache_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];

  // A push into a full buffer is dropped and leaves the write pointer alone.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/main_to_cache_refill.sv
// Cache line refill controller: issues one word read per line word to main
// memory, buffers in-order responses, and streams them to the cache.
module main_to_cache_refill
  import kasumi_cache_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_valid,
  input  logic [FIFO_WIDTH-1:0] miss_addr,
  output logic                  miss_ready,
  output logic                  mem_req_valid,
  output logic [FIFO_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [FIFO_WIDTH-1:0] mem_resp_data,
  output logic                  fill_valid,
  output logic [FIFO_WIDTH-1:0] fill_data,
  output logic [FIFO_WIDTH-1:0] fill_addr,
  input  logic                  fill_ready,
  output logic                  fill_done,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned OFF_W  = line_off_w(LINE_WORDS);
  localparam int unsigned WCNT_W = $clog2(LINE_WORDS) + 1;
  localparam int unsigned OCC_W  = $clog2(DEPTH) + 1;
  localparam logic [FIFO_WIDTH-1:0] OFF_MASK =
    FIFO_WIDTH'((64'd1 << OFF_W) - 64'd1);

  refill_state_e          state_q;
  refill_state_e          state_d;
  logic [FIFO_WIDTH-1:0]  base_q;
  logic [WCNT_W-1:0]      issued_q;
  logic [WCNT_W-1:0]      popped_q;
  logic [OCC_W-1:0]       outstanding_q;
  logic [OCC_W-1:0]       occupancy;
  logic [OCC_W:0]         credit_used;
  logic                   credit_ok;
  logic                   miss_fire;
  logic                   req_fire;
  logic                   resp_take;
  logic                   fill_fire;
  logic                   fifo_empty;

  // Requests in flight plus words already buffered may never exceed DEPTH,
  // so every response is guaranteed a slot without memory backpressure.
  assign credit_used = (OCC_W+1)'(outstanding_q) + (OCC_W+1)'(occupancy);
  assign credit_ok   = (credit_used < (OCC_W+1)'(DEPTH));

  assign miss_fire = miss_valid && miss_ready;
  assign req_fire  = mem_req_valid && mem_req_ready;
  assign resp_take = mem_resp_valid && ((state_q == ISSUE) || (state_q == DRAIN));
  assign fill_fire = fill_valid && fill_ready;

  assign fill_valid   = !fifo_empty;
  assign empty        = fifo_empty;
  assign mem_req_addr = base_q + (FIFO_WIDTH'(issued_q) << 2);
  assign fill_addr    = base_q + (FIFO_WIDTH'(popped_q) << 2);

  cache_sync_fifo #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (resp_take),
    .wr_data (mem_resp_data),
    .pop     (fill_fire),
    .rd_data (fill_data),
    .full    (full),
    .empty   (fifo_empty),
    .count   (occupancy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d       = state_q;
    miss_ready    = 1'b0;
    mem_req_valid = 1'b0;
    fill_done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) state_d = ISSUE;
      end
      ISSUE: begin
        mem_req_valid = credit_ok;
        if (credit_ok && mem_req_ready && (issued_q == WCNT_W'(LINE_WORDS - 1)))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (fill_fire && (popped_q == WCNT_W'(LINE_WORDS - 1)))
          state_d = DONE;
      end
      DONE: begin
        fill_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line base, word counters and the in-flight request count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q        <= '0;
      issued_q      <= '0;
      popped_q      <= '0;
      outstanding_q <= '0;
    end else begin
      if (miss_fire) begin
        base_q   <= miss_addr & ~OFF_MASK;
        issued_q <= '0;
        popped_q <= '0;
      end else begin
        if (req_fire)  issued_q <= issued_q + WCNT_W'(1);
        if (fill_fire) popped_q <= popped_q + WCNT_W'(1);
      end
      unique case ({req_fire, resp_take})
        2'b10:   outstanding_q <= outstanding_q + OCC_W'(1);
        2'b01:   outstanding_q <= outstanding_q - OCC_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

endmodule
